// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor start/step/quit pulses into single-cycle
// cpu_start / quit_cmd strobes, with N-instruction stepping, a PC breakpoint,
// a post-stop drain window, and start deferral until DRAM calibration is done.
module cpu_run_ctrl #(
  parameter int STEP_W    = 16,
  parameter int DRAIN_CYC = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              cmd_start,
  input  logic              cmd_step,
  input  logic              cmd_quit,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic              brk_en,
  input  logic [31:0]       brk_addr,
  input  logic [31:0]       pc_ex,
  input  logic              pc_adv,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              running,
  output logic              brk_hit,
  output logic              step_done
);

  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_STEP, S_STOP} state_t;

  state_t            state, state_nxt;
  logic              armed_step, armed_step_nxt;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic [DRN_W-1:0]  drain, drain_nxt;
  logic              cpu_start_nxt, quit_nxt, brk_hit_nxt, step_done_nxt;
  logic              brk_match, cnt_end;

  // Breakpoint only counts when the EX instruction actually retires this cycle.
  assign brk_match = pc_adv & brk_en & (pc_ex == brk_addr);
  assign cnt_end   = (state == S_STEP) & pc_adv & (cnt == STEP_W'(1));
  assign running   = (state == S_RUN) | (state == S_STEP);

  // State, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      armed_step <= 1'b0;
      cnt        <= '0;
      drain      <= '0;
      cpu_start  <= 1'b0;
      quit_cmd   <= 1'b0;
      brk_hit    <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      armed_step <= armed_step_nxt;
      cnt        <= cnt_nxt;
      drain      <= drain_nxt;
      cpu_start  <= cpu_start_nxt;
      quit_cmd   <= quit_nxt;
      brk_hit    <= brk_hit_nxt;
      step_done  <= step_done_nxt;
    end
  end

  // Next-state and next-strobe decode.
  always_comb begin
    state_nxt      = state;
    armed_step_nxt = armed_step;
    cnt_nxt        = cnt;
    drain_nxt      = drain;
    cpu_start_nxt  = 1'b0;
    quit_nxt       = 1'b0;
    brk_hit_nxt    = brk_hit;
    step_done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        // Start wins over step when both arrive together.
        if (cmd_start | cmd_step) begin
          brk_hit_nxt    = 1'b0;
          armed_step_nxt = ~cmd_start;
          if (!cmd_start)
            cnt_nxt = (step_cnt == '0) ? STEP_W'(1) : step_cnt;
          if (init_calib_complete) begin
            state_nxt     = cmd_start ? S_RUN : S_STEP;
            cpu_start_nxt = 1'b1;
          end else begin
            state_nxt = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (cmd_quit) begin
          state_nxt = S_IDLE;
        end else if (init_calib_complete) begin
          state_nxt     = armed_step ? S_STEP : S_RUN;
          cpu_start_nxt = 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        if ((state == S_STEP) && pc_adv)
          cnt_nxt = cnt - STEP_W'(1);
        if (cmd_quit | brk_match | cnt_end) begin
          // All stop causes merge into a single quit strobe.
          state_nxt = S_STOP;
          drain_nxt = DRN_W'(DRAIN_CYC - 1);
          quit_nxt  = 1'b1;
          if (brk_match) brk_hit_nxt   = 1'b1;
          if (cnt_end)   step_done_nxt = 1'b1;
        end else if (!init_calib_complete) begin
          // Status block halts on its own here; no quit strobe needed.
          state_nxt = S_STOP;
          drain_nxt = DRN_W'(DRAIN_CYC - 1);
        end
      end
      S_STOP: begin
        if (drain == '0) state_nxt = S_IDLE;
        else             drain_nxt = drain - DRN_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven bench for cpu_run_ctrl plus hand sequences for
// simultaneous stop causes and asynchronous reset.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_calib_complete, cmd_start, cmd_step, cmd_quit;
  logic [15:0] step_cnt;
  logic        brk_en;
  logic [31:0] brk_addr, pc_ex;
  logic        pc_adv;
  logic        cpu_start, quit_cmd, running, brk_hit, step_done;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.STEP_W(16), .DRAIN_CYC(5)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_quit(cmd_quit),
    .step_cnt(step_cnt), .brk_en(brk_en), .brk_addr(brk_addr), .pc_ex(pc_ex),
    .pc_adv(pc_adv), .cpu_start(cpu_start), .quit_cmd(quit_cmd),
    .running(running), .brk_hit(brk_hit), .step_done(step_done)
  );

  always #5 clk = ~clk;

  // Expected field order: {cpu_start, quit_cmd, running, brk_hit, step_done}
  typedef struct {
    logic        calib, start, step, quit;
    logic [15:0] scnt;
    logic        ben;
    logic [31:0] pc;
    logic        adv;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, s, st, q, input logic [15:0] n,
                              input logic be, input logic [31:0] p,
                              input logic a, input logic [4:0] e);
    vec_t v;
    v.calib = c; v.start = s; v.step = st; v.quit = q; v.scnt = n;
    v.ben = be; v.pc = p; v.adv = a; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {cpu_start, quit_cmd, running, brk_hit, step_done};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b (cs,q,run,bh,sd)", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    init_calib_complete = v.calib; cmd_start = v.start; cmd_step = v.step;
    cmd_quit = v.quit; step_cnt = v.scnt; brk_en = v.ben; pc_ex = v.pc;
    pc_adv = v.adv;
  endtask

  // Push n idle cycles (calib high) with the given expected outputs.
  task automatic idle(input int n, input logic [4:0] e);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, e));
  endtask

  initial begin
    int qcnt, scnt_seen;
    rst_n = 1'b0;
    brk_addr = 32'h0000_0040;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // 1: free run, quit, 5-cycle drain (start ignored until IDLE)
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b10100));
    idle(1, 5'b00100);
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b01000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    idle(2, 5'b00000);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b01000));
    idle(5, 5'b00000);
    // 2: start held in ARMED until calibration
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b01000));
    idle(5, 5'b00000);
    // 3: step 3 with stalls, then step_cnt=0 behaves as 1
    tbl.push_back(mk(1, 0, 1, 0, 3, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5'b01001));
    idle(5, 5'b00000);
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5'b01001));
    idle(5, 5'b00000);
    // 4: breakpoint needs pc_adv; brk_hit sticky until next accept
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h40, 0, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h44, 1, 5'b00100));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h40, 1, 5'b01010));
    idle(5, 5'b00010);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b01000));
    idle(5, 5'b00000);
    // 6b: calibration drop in RUN stops without a quit strobe
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b10100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    idle(5, 5'b00000);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 5'b00000);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // 5: count end + breakpoint + cmd_quit together -> one quit strobe
    @(negedge clk); drive(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #1; check("t5_step_accept", outs(), 5'b10100);
    @(negedge clk); drive(mk(1, 0, 0, 1, 0, 1, 32'h40, 1, 0));
    @(posedge clk); #1; check("t5_triple_stop", outs(), 5'b01011);
    qcnt = 0; scnt_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      qcnt += int'(quit_cmd); scnt_seen += int'(cpu_start);
    end
    check("t5_extra_quit", 5'(qcnt), 5'd0);
    check("t5_start_in_stop", 5'(scnt_seen), 5'd0);
    check("t5_sticky", outs(), 5'b00010);
    // Now IDLE: start accepted, clears brk_hit
    @(posedge clk); #1; check("t5_after_drain", outs(), 5'b10100);

    // 6a: asynchronous reset in RUN clears outputs immediately
    @(negedge clk); drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; check("t6_running", outs(), 5'b00100);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", outs(), 5'b00000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; check("t6_idle_after_reset", outs(), 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
